ble_button_parser: RTL

Packet parser between `uart_rx` and `gameplay`. It assembles Bluefruit-style controller button packets from the received UART byte stream and validates each packet's checksum. It emits one event per valid packet on a byte/strobe pair that connects directly to `gameplay`'s `user_input`/`user_rdy`. It also keeps a persistent 8-button state vector and a packet-error strobe for debug display.

---
 rtl/ble_button_parser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ble_button_parser.sv
// Bluefruit-style button packet parser: assembles "!B<id><act><chk>" frames from a
// UART byte stream, emits one event per valid packet, and tracks held buttons.
module ble_button_parser #(
    parameter int TIMEOUT_CYCLES = 742500,
    parameter int TW             = 20
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] evt_data,
    output logic       evt_valid,
    output logic [7:0] btn_state,
    output logic       pkt_err
);

    localparam logic [7:0]    BYTE_BANG = 8'h21;
    localparam logic [7:0]    BYTE_B    = 8'h42;
    localparam logic [TW-1:0] T_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_ID,
        ST_ACT,
        ST_SUM
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    sum_reg, sum_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic [2:0]    id_reg, id_next;
    logic          pressed_reg, pressed_next;
    logic [7:0]    evt_data_reg, evt_data_next;
    logic          evt_valid_reg, evt_valid_next;
    logic [7:0]    btn_state_reg, btn_state_next;
    logic          pkt_err_reg, pkt_err_next;
    logic          evt_fire;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg     <= ST_IDLE;
            sum_reg       <= 8'h00;
            cnt_reg       <= '0;
            id_reg        <= 3'd0;
            pressed_reg   <= 1'b0;
            evt_data_reg  <= 8'h00;
            evt_valid_reg <= 1'b0;
            btn_state_reg <= 8'h00;
            pkt_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            cnt_reg       <= cnt_next;
            id_reg        <= id_next;
            pressed_reg   <= pressed_next;
            evt_data_reg  <= evt_data_next;
            evt_valid_reg <= evt_valid_next;
            btn_state_reg <= btn_state_next;
            pkt_err_reg   <= pkt_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        id_next        = id_reg;
        pressed_next   = pressed_reg;
        evt_data_next  = evt_data_reg;
        evt_valid_next = 1'b0;
        pkt_err_next   = 1'b0;
        evt_fire       = 1'b0;

        if (valid_in)
            cnt_next = '0;
        else if (state_reg != ST_IDLE && cnt_reg < T_MAX)
            cnt_next = cnt_reg + 1'b1;
        else
            cnt_next = cnt_reg;

        if (valid_in) begin
            case (state_reg)
                ST_IDLE: begin
                    if (data_in == BYTE_BANG) begin
                        state_next = ST_TYPE;
                        sum_next   = BYTE_BANG;
                    end
                end
                ST_TYPE: begin
                    if (data_in == BYTE_B) begin
                        state_next = ST_ID;
                        sum_next   = sum_reg + data_in;
                    end else if (data_in == BYTE_BANG) begin
                        sum_next = BYTE_BANG;
                    end else begin
                        pkt_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
                ST_ID: begin
                    if (data_in >= 8'h31 && data_in <= 8'h38) begin
                        state_next = ST_ACT;
                        // '1'..'8' map to 0..7 through the low three bits minus one
                        id_next    = data_in[2:0] - 3'd1;
                        sum_next   = sum_reg + data_in;
                    end else if (data_in == BYTE_BANG) begin
                        state_next = ST_TYPE;
                        sum_next   = BYTE_BANG;
                    end else begin
                        pkt_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
                ST_ACT: begin
                    if (data_in == 8'h30 || data_in == 8'h31) begin
                        state_next   = ST_SUM;
                        pressed_next = data_in[0];
                        sum_next     = sum_reg + data_in;
                    end else if (data_in == BYTE_BANG) begin
                        state_next = ST_TYPE;
                        sum_next   = BYTE_BANG;
                    end else begin
                        pkt_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
                ST_SUM: begin
                    // Any value is a checksum candidate here, 0x21 included
                    if (data_in == ~sum_reg) begin
                        evt_fire       = 1'b1;
                        evt_valid_next = 1'b1;
                        evt_data_next  = {4'b0000, pressed_reg, id_reg};
                    end else begin
                        pkt_err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE && cnt_reg == T_LAST) begin
            pkt_err_next = 1'b1;
            state_next   = ST_IDLE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_btn
            always_comb begin
                btn_state_next[gi] = btn_state_reg[gi];
                if (evt_fire && id_reg == 3'(gi))
                    btn_state_next[gi] = pressed_reg;
            end
        end
    endgenerate

    assign evt_data  = evt_data_reg;
    assign evt_valid = evt_valid_reg;
    assign btn_state = btn_state_reg;
    assign pkt_err   = pkt_err_reg;

endmodule
